// File: rtl/simple_out_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : simple_out_deserializer_if
//  Brief    : Sample strobe, word valid/ready and status bundle for the
//             simple_out_deserializer capture stage.
//  Revision : 1.0  initial release
// ============================================================================
interface simple_out_deserializer_if #(
    parameter int WIDTH = 8,
    parameter int TCW   = 16
);
    logic             in_bit;
    logic             in_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;
    logic [TCW-1:0]   toggle_cnt;

    // master = deserializer side, slave = producer/consumer side
    modport master (
        input  in_bit, in_en, word_ready,
        output word_out, word_valid, overflow, toggle_cnt
    );
    modport slave (
        output in_bit, in_en, word_ready,
        input  word_out, word_valid, overflow, toggle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/simple_out_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : simple_out_deserializer
//  Brief    : Packs the core's sampled out bit into WIDTH-bit words, buffers
//             them in a 2-entry FIFO and counts sampled-bit transitions.
//  Revision : 1.0  initial release
// ============================================================================
module simple_out_deserializer #(
    parameter int WIDTH = 8,
    parameter int TCW   = 16
) (
    input  wire logic                    iccad_clk,
    input  wire logic                    iccad_rst,
    simple_out_deserializer_if.master    bus
);
    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [TCW-1:0]     c_TMAX  = {TCW{1'b1}};

    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_bitcnt;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic [1:0]         r_count;
    logic               r_overflow;
    logic [TCW-1:0]     r_toggle;
    logic               r_prev_bit;
    logic               r_prev_vld;

    logic [WIDTH-1:0]   w_shift_next;
    logic               w_push;
    logic               w_pop;
    logic               w_toggle;

    always_comb begin
        w_shift_next           = r_shift;
        w_shift_next[r_bitcnt] = bus.in_bit;
    end

    // Completed word is taken from w_shift_next so it includes the final bit
    assign w_push   = bus.in_en && (r_bitcnt == c_LAST);
    assign w_pop    = (r_count != 2'd0) && bus.word_ready;
    assign w_toggle = bus.in_en && r_prev_vld && (bus.in_bit != r_prev_bit)
                      && (r_toggle != c_TMAX);

    always_ff @(posedge iccad_clk) begin
        if (iccad_rst) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
            r_toggle   <= '0;
            r_prev_bit <= 1'b0;
            r_prev_vld <= 1'b0;
        end else begin
            if (bus.in_en) begin
                r_shift    <= w_shift_next;
                r_bitcnt   <= (r_bitcnt == c_LAST) ? '0 : (r_bitcnt + c_ONE);
                r_prev_bit <= bus.in_bit;
                r_prev_vld <= 1'b1;
            end
            if (w_toggle) begin
                r_toggle <= r_toggle + {{(TCW-1){1'b0}}, 1'b1};
            end

            // Head register always drives word_out; tail is only the 2nd slot
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= w_shift_next;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_shift_next;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end else if (w_push) begin
                        r_tail  <= w_shift_next;
                        r_count <= 2'd2;
                    end
                end
                2'd2: begin
                    if (w_push && w_pop) begin
                        r_head <= r_tail;
                        r_tail <= w_shift_next;
                    end else if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end else if (w_push) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
        end
    end

    assign bus.word_out   = r_head;
    assign bus.word_valid = (r_count != 2'd0);
    assign bus.overflow   = r_overflow;
    assign bus.toggle_cnt = r_toggle;

endmodule
`default_nettype wire

// File: tb/tb_simple_out_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simple_out_deserializer
//  Brief    : Directed scoreboard bench for simple_out_deserializer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_simple_out_deserializer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] exp_q[$];

    simple_out_deserializer_if #(.WIDTH(8), .TCW(16)) bus0 ();
    simple_out_deserializer_if #(.WIDTH(8), .TCW(4))  bus1 ();

    simple_out_deserializer #(.WIDTH(8), .TCW(16)) u_dut (
        .iccad_clk (clk),
        .iccad_rst (rst),
        .bus       (bus0)
    );

    // Narrow-counter copy shares the sample stream for the saturation case
    simple_out_deserializer #(.WIDTH(8), .TCW(4)) u_dut_sat (
        .iccad_clk (clk),
        .iccad_rst (rst),
        .bus       (bus1)
    );
    assign bus1.in_bit     = bus0.in_bit;
    assign bus1.in_en      = bus0.in_en;
    assign bus1.word_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the queue head
    always @(negedge clk) begin
        if (!rst && bus0.word_valid && bus0.word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected actual=0x%0h required=none", bus0.word_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus0.word_out !== e) begin
                    failures++;
                    $display("FAIL word_out actual=0x%0h required=0x%0h", bus0.word_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus0.in_en  = 1'b0;
        rst         = 1'b1;
        tick();
        rst         = 1'b0;
    endtask

    task automatic sample(input logic b);
        bus0.in_bit = b;
        bus0.in_en  = 1'b1;
        tick();
        bus0.in_en  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit gaps, input bit ready_on_last);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                bus0.in_bit = ~w[i];
                bus0.in_en  = 1'b0;
                tick();
            end
            if (ready_on_last && i == 7) bus0.word_ready = 1'b1;
            sample(w[i]);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        bus0.in_bit     = 1'b0;
        bus0.in_en      = 1'b0;
        bus0.word_ready = 1'b0;
        rst             = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid",    {31'd0, bus0.word_valid}, 32'd0);
        check("rst_word",     {24'd0, bus0.word_out},   32'd0);
        check("rst_overflow", {31'd0, bus0.overflow},   32'd0);
        check("rst_toggle",   {16'd0, bus0.toggle_cnt}, 32'd0);

        // Basic word: bits 1,0,1,1,0,0,1,0 -> 0x4D, 5 transitions
        bus0.word_ready = 1'b1;
        exp_q.push_back(8'h4D);
        send_word(8'h4D, 1'b0, 1'b0);
        check("basic_valid_lat", {31'd0, bus0.word_valid}, 32'd1);
        check("basic_word",      {24'd0, bus0.word_out},   32'h4D);
        check("basic_toggle",    {16'd0, bus0.toggle_cnt}, 32'd5);
        tick();
        check("basic_valid_once", {31'd0, bus0.word_valid}, 32'd0);
        check("basic_overflow",   {31'd0, bus0.overflow},   32'd0);

        // Strobe gaps with in_bit toggling while in_en=0
        do_reset();
        exp_q.push_back(8'h4D);
        send_word(8'h4D, 1'b1, 1'b0);
        tick();
        check("gap_toggle", {16'd0, bus0.toggle_cnt}, 32'd5);

        // Backpressure and overflow: 0x33 is dropped
        do_reset();
        bus0.word_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        check("bp_overflow", {31'd0, bus0.overflow},   32'd1);
        check("bp_head",     {24'd0, bus0.word_out},   32'h11);
        check("bp_valid",    {31'd0, bus0.word_valid}, 32'd1);
        bus0.word_ready = 1'b1;
        tick();
        tick();
        check("bp_drained",       {31'd0, bus0.word_valid}, 32'd0);
        check("bp_overflow_hold", {31'd0, bus0.overflow},   32'd1);

        // Full FIFO with push and pop on the same edge
        do_reset();
        check("ovf_cleared", {31'd0, bus0.overflow}, 32'd0);
        bus0.word_ready = 1'b0;
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        send_word(8'hA1, 1'b0, 1'b0);
        send_word(8'hA2, 1'b0, 1'b0);
        send_word(8'hA3, 1'b0, 1'b1);
        check("pp_overflow", {31'd0, bus0.overflow}, 32'd0);
        check("pp_head",     {24'd0, bus0.word_out}, 32'hA2);
        tick();
        tick();
        check("pp_drained", {31'd0, bus0.word_valid}, 32'd0);

        // Reset mid-word after five zero samples
        do_reset();
        bus0.word_ready = 1'b1;
        for (int i = 0; i < 5; i++) sample(1'b0);
        do_reset();
        check("mid_valid",    {31'd0, bus0.word_valid}, 32'd0);
        check("mid_word",     {24'd0, bus0.word_out},   32'd0);
        check("mid_overflow", {31'd0, bus0.overflow},   32'd0);
        check("mid_toggle",   {16'd0, bus0.toggle_cnt}, 32'd0);
        exp_q.push_back(8'hFF);
        send_word(8'hFF, 1'b0, 1'b0);
        check("mid_word_ff", {24'd0, bus0.word_out},   32'hFF);
        check("mid_first",   {16'd0, bus0.toggle_cnt}, 32'd0);
        tick();

        // Saturation: 20 alternating samples -> words 0xAA, 0xAA
        do_reset();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 20; i++) begin
            sample(i[0]);
            if (i == 9) check("sat_pre", {28'd0, bus1.toggle_cnt}, 32'd9);
        end
        check("sat_wide",   {16'd0, bus0.toggle_cnt}, 32'd19);
        check("sat_narrow", {28'd0, bus1.toggle_cnt}, 32'hF);
        sample(1'b1);
        check("sat_hold",   {28'd0, bus1.toggle_cnt}, 32'hF);
        tick();
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/simple_out_deserializer.md
# simple_out_deserializer

Downstream capture stage for the `simple` gate-level core. It samples the core's single-bit `out` net into WIDTH-bit words, buffers completed words in a 2-entry FIFO, and presents them on a valid/ready interface. It also keeps a saturating count of sampled-bit transitions. It runs in the core's `iccad_clk` domain and is the first consumer of the core's primary output.

## Interface
- WIDTH, default 8: bits per word; legal range 2..32.
- TCW, default 16: width of the transition counter.

- iccad_clk  in  1  core clock; all state changes on its rising edge.
- iccad_rst  in  1  reset, synchronous, active-high.
- in_bit  in  1  sampled data; driven by the core's `out`.
- in_en  in  1  sample strobe; `in_bit` is captured only on edges where this is 1.
- word_out  out  WIDTH  FIFO head word. Bit k is the k-th sample of that word (first sample lands in bit 0).
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accept; a pop occurs when `word_valid & word_ready`.
- overflow  out  1  sticky; set when a completed word is dropped.
- toggle_cnt  out  TCW  saturating count of `in_bit` changes between consecutive accepted samples.

## Operation
- Reset (`iccad_rst`=1 at an edge):
  - FIFO emptied, so `word_valid`=0 and `word_out`=0.
  - Bit counter = 0, shift register = 0.
  - `overflow`=0, `toggle_cnt`=0, previous-sample-valid flag = 0.
  - Reset has priority over every other event, including a reset that arrives mid-word.
- Sampling (`in_en`=1):
  - `in_bit` is written to shift position `bitcnt`, then `bitcnt` increments.
  - When the captured bit is position WIDTH-1, the word is complete, `bitcnt` wraps to 0, and the word is pushed into the FIFO.
  - `in_en`=0 holds all capture state.
- FIFO: 2 entries, in-order. Push and pop are resolved in the same cycle:
  - Empty + push: 1 entry.
  - 1 entry + push + pop: 1 entry (the new word).
  - Full + push + pop: stays full; the head advances and the new word goes to the tail. No drop.
  - Full + push, no pop: the word is dropped and `overflow` is set. It stays set until reset.
  - Pop when empty is impossible because `word_valid`=0.
- Transition counter:
  - On each accepted sample, if the previous-sample-valid flag is set and `in_bit` differs from the previous sample, `toggle_cnt` increments. It saturates at 2^TCW-1.
  - Transitions are counted across word boundaries.
  - The first sample after reset sets the flag and does not count.
- `word_out` and `word_valid` are registered FIFO outputs with no combinational path from `word_ready`. `word_out` is stable while `word_valid`=1 and no pop occurs.

## Timing
- Latency: a word whose last bit is sampled at edge t shows `word_valid`=1 in the cycle after edge t (0 extra cycles).
- A pop at edge t exposes the next entry, or `word_valid`=0, in the cycle after edge t.
- Throughput: one word per WIDTH sampling edges. The FIFO never limits throughput while `word_ready` is held high.
- `overflow` and `toggle_cnt` update at the same edge as the triggering sample.
- Reset takes effect at the edge where `iccad_rst`=1. Outputs show reset values in the following cycle.

## Test plan
- **Basic word.** WIDTH=8, `word_ready`=1, `in_en`=1, bits 1,0,1,1,0,0,1,0.
  - `word_out`=0x4D with `word_valid`=1 for exactly one cycle after the 8th edge.
  - `toggle_cnt`=5, `overflow`=0.
- **Strobe gaps.** Same 8 bits, with `in_en`=0 cycles between them and `in_bit` toggling during those cycles.
  - Result still 0x4D, `toggle_cnt`=5.
- **Backpressure and overflow.** `word_ready`=0; feed words 0x11, 0x22, 0x33.
  - After the 24th sample: `overflow`=1, `word_out`=0x11.
  - Raise `word_ready`: 0x11 then 0x22 on consecutive cycles, then `word_valid`=0. 0x33 is lost.
- **Full with simultaneous push/pop.** FIFO holds 0xA1, 0xA2. Assert `word_ready` on the same edge that 0xA3 completes.
  - `overflow` stays 0.
  - Words are delivered in order 0xA2, 0xA3.
- **Reset mid-word.** After 5 samples, pulse `iccad_rst` for one cycle.
  - All outputs 0.
  - The next 8 samples (0xFF) yield `word_out`=0xFF. The earlier partial bits do not appear.
  - The first post-reset sample is not counted.
- **Saturation.** TCW=4, alternating bits for 20 samples.
  - `toggle_cnt`=0xF and holds there.
